uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//  UART receiver, 8N1, LSB first; the downstream partner of the team's UART transmitter.
//  Samples the serial line at mid-bit and captures the data byte.
//  Presents each byte with a one-cycle valid strobe plus sticky full/overrun status.
//  Sits between the board RX pin (or the TX OUT in loopback) and the byte consumer.
//  Bit period matches the transmitter: KBAUD+1 clk cycles per bit.
// PARAMETERS
//  KBAUD     14'd10416  bit period minus 1, in clk cycles (100 MHz / 9600 baud)
//  CNT_BITS  $clog2(KBAUD)+1  baud counter width (must hold KBAUD)
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst        in   1         reset, asynchronous, active-low
//  rx_in      in   1         serial line, asynchronous to clk, idle high
//  Rx_rd      in   1         consumer read strobe; clears Rx_full
//  data       out  8         last correctly framed byte
//  Rx_valid   out  1         1-cycle pulse when data updates
//  Rx_full    out  1         byte held and not yet read
//  Rx_busy    out  1         1 whenever state != IDLE_s
//  frame_err  out  1         stop bit sampled low on last frame; cleared by next good frame
//  overrun    out  1         sticky; new byte arrived while Rx_full=1 and no Rx_rd that cycle
// BEHAVIOUR
//  Reset (rst=0, any time, incl. mid-frame): sync FFs=1, state=IDLE_s, counters=0, shift=0.
//   Outputs at reset: data=0, Rx_valid=0, Rx_full=0, frame_err=0, overrun=0.
//  Synchroniser: rx_in goes through 2 FFs to rx_s; FSM reacts only to rx_s.
//  Baud counter: cnt clears on every state change and counts 0..KBAUD. HALF=(KBAUD+1)/2.
//  States and transitions:
//   IDLE_s:  if rx_s==0 -> START_s, cnt=0.
//   START_s: at cnt==HALF-1, sample rx_s.
//            rx_s==0 -> DATA_s, cnt=0, bit_idx=0.
//            rx_s==1 -> IDLE_s (glitch; no flags, no output).
//   DATA_s:  at cnt==KBAUD, shift = {rx_s, shift[7:1]}, bit_idx++. Samples stay mid-bit.
//            After the 8th sample (bit_idx==7) -> STOP_s, cnt=0.
//   STOP_s:  at cnt==KBAUD, sample rx_s.
//            rx_s==1 -> data=shift, Rx_valid=1 for one cycle, frame_err=0, Rx_full=1 -> IDLE_s.
//            rx_s==0 -> frame_err=1, data/Rx_full unchanged, no Rx_valid -> BREAK_s.
//   BREAK_s: wait until rx_s==1 -> IDLE_s. A held-low line never re-triggers a start.
//  Full/read rules:
//   Rx_rd alone clears Rx_full next cycle. Rx_rd while Rx_full=0: no effect.
//   Rx_rd in the same cycle as Rx_valid: Rx_full stays 1, data takes the new byte, no overrun.
//   Rx_valid with Rx_full=1 and Rx_rd=0: data overwritten, overrun=1 (cleared only by reset).
//  Latency: Rx_valid asserts 1 cycle after the stop-bit sample point.
//   The stop-bit sample point is about 9.5 bit periods + 2 clk after the rx_in falling edge.
//  Tolerance: mid-bit sampling; at most +/-4% baud mismatch is accepted. No re-sync within a frame.
//  Consecutive frames: a start bit immediately following the stop bit is captured.
//   (IDLE_s re-entered at mid-stop.)
// TESTING (bench KBAUD=15: 16 clk/bit, HALF=8)
//  Send byte 8'hA5, stop bit 1 -> one Rx_valid pulse, data=8'hA5, Rx_full=1, frame_err=0.
//  Start-bit glitch: rx_in low for 4 clk -> Rx_busy pulses, returns to IDLE, no Rx_valid.
//  Send 8'h3C with stop bit 0, line held low 40 clk then high -> frame_err=1, no Rx_valid.
//   Continue: stays in BREAK_s until high; next byte 8'h01 then gives data=8'h01, frame_err=0.
//  Send 8'h11 then 8'h22 back-to-back, no Rx_rd -> data=8'h22, overrun=1.
//   Repeat with Rx_rd pulsed on the 2nd Rx_valid cycle -> overrun=0, Rx_full=1.
//  Loopback from the team's UART transmitter (same KBAUD), bytes 8'h00, 8'hFF, 8'h55, 8'hAA
//   -> all four received in order, no errors.
//  Assert rst=0 mid-DATA_s (after 3 bits) -> all outputs 0 immediately.
//   Next full frame 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1 LSB-first UART receiver with mid-bit sampling, a one-cycle byte strobe
// and full/overrun/frame-error status.
module uart_rx_os #(
    parameter logic [13:0] KBAUD    = 14'd10416,
    parameter int          CNT_BITS = $clog2(KBAUD) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       Rx_rd,
    output logic [7:0] data,
    output logic       Rx_valid,
    output logic       Rx_full,
    output logic       Rx_busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam logic [CNT_BITS-1:0] TOP = CNT_BITS'(KBAUD);
    localparam logic [CNT_BITS-1:0] MID = CNT_BITS'((KBAUD + 14'd1) / 14'd2 - 14'd1);

    typedef enum logic [2:0] {IDLE_s, START_s, DATA_s, STOP_s, BREAK_s} state_t;

    state_t              r_state, w_next;
    logic [1:0]          r_sync;
    logic [CNT_BITS-1:0] r_cnt;
    logic [2:0]          r_idx;
    logic [7:0]          r_shift;
    logic                w_rx, w_top, w_mid, w_good, w_bad;

    assign w_rx  = r_sync[1];
    assign w_top = r_cnt == TOP;
    assign w_mid = r_cnt == MID;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE_s;
            r_sync  <= 2'b11;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_sync  <= {r_sync[0], rx_in};
            r_cnt   <= (w_next != r_state || w_top) ? '0 : r_cnt + CNT_BITS'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE_s:  if (!w_rx) w_next = START_s;
            START_s: if (w_mid) w_next = w_rx ? IDLE_s : DATA_s;
            DATA_s:  if (w_top && r_idx == 3'd7) w_next = STOP_s;
            STOP_s:  if (w_top) w_next = w_rx ? IDLE_s : BREAK_s;
            BREAK_s: if (w_rx) w_next = IDLE_s;
            default: w_next = IDLE_s;
        endcase
    end

    always_comb begin
        Rx_busy = r_state != IDLE_s;
        w_good  = r_state == STOP_s && w_top && w_rx;
        w_bad   = r_state == STOP_s && w_top && !w_rx;
    end

    // Full/overrun are decided in the Rx_valid cycle, so a read in that cycle absorbs the new byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx     <= '0;
            r_shift   <= '0;
            data      <= '0;
            Rx_valid  <= 1'b0;
            Rx_full   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_idx <= (r_state != DATA_s) ? 3'd0 : r_idx + {2'b00, w_top};
            if (r_state == DATA_s && w_top) r_shift <= {w_rx, r_shift[7:1]};
            if (w_good) data <= r_shift;
            Rx_valid  <= w_good;
            frame_err <= w_good ? 1'b0 : (w_bad ? 1'b1 : frame_err);
            Rx_full   <= Rx_valid | (Rx_full & ~Rx_rd);
            overrun   <= overrun | (Rx_valid & Rx_full & ~Rx_rd);
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard-driven bench for uart_rx_os at 16 clk per bit.
module tb_uart_rx_os;
    localparam int BIT = 16;

    logic       clk = 1'b0, rst = 1'b0, rx_in = 1'b1, Rx_rd = 1'b0;
    logic [7:0] data;
    logic       Rx_valid, Rx_full, Rx_busy, frame_err, overrun;
    int         n_chk = 0, n_fail = 0, n_valid = 0;
    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic       prev_v = 1'b0;

    uart_rx_os #(.KBAUD(14'd15)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .Rx_rd(Rx_rd), .data(data),
        .Rx_valid(Rx_valid), .Rx_full(Rx_full), .Rx_busy(Rx_busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Serial model of the transmitter: start, 8 data LSB first, stop; called and returns at negedge
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx_in = stop;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = Rx_valid;
        end
    endtask

    task automatic pulse_rd;
        Rx_rd = 1'b1;
        @(negedge clk);
        Rx_rd = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({data, Rx_valid, Rx_full, Rx_busy, frame_err, overrun} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h v=%b f=%b b=%b fe=%b ov=%b, expected all 0",
                     data, Rx_valid, Rx_full, Rx_busy, frame_err, overrun);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic;
        int v0 = n_valid;
        q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin n_fail++; $display("FAIL basic_missing: %0d bytes pending, expected 0", q.size()); end
        n_chk++;
        if (n_valid != v0 + 1) begin n_fail++; $display("FAIL basic_pulses: got %0d, expected 1", n_valid - v0); end
        n_chk++;
        if (data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h, expected a5", data); end
        n_chk++;
        if (Rx_full !== 1'b1 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL basic_status: got full=%b fe=%b, expected full=1 fe=0", Rx_full, frame_err);
        end
        pulse_rd();
        @(negedge clk);
        n_chk++;
        if (Rx_full !== 1'b0) begin n_fail++; $display("FAIL read_clears_full: got %b, expected 0", Rx_full); end
    endtask

    task automatic test_glitch;
        int   v0 = n_valid;
        logic saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rx_in = (i >= 4);
            @(negedge clk);
            saw |= Rx_busy;
        end
        n_chk++;
        if (saw !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_pulse: got %b, expected 1", saw); end
        n_chk++;
        if (Rx_busy !== 1'b0 || n_valid != v0) begin
            n_fail++; $display("FAIL glitch_idle: got busy=%b pulses=%0d, expected busy=0 pulses=0", Rx_busy, n_valid - v0);
        end
    endtask

    task automatic test_frame_err;
        int v0 = n_valid;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        n_chk++;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b, expected 1", frame_err); end
        n_chk++;
        if (Rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_hold: got busy=%b, expected 1", Rx_busy); end
        n_chk++;
        if (n_valid != v0 || data !== 8'hA5) begin
            n_fail++; $display("FAIL ferr_no_output: got pulses=%0d data=%h, expected 0 and a5", n_valid - v0, data);
        end
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        n_chk++;
        if (Rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_break_exit: got busy=%b, expected 0", Rx_busy); end
        q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++;
        if (data !== 8'h01 || frame_err !== 1'b0 || q.size() != 0) begin
            n_fail++; $display("FAIL ferr_recover: got data=%h fe=%b pending=%0d, expected 01 0 0", data, frame_err, q.size());
        end
        pulse_rd();
        @(negedge clk);
    endtask

    task automatic test_overrun;
        q.push_back(8'h11);
        q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++;
        if (data !== 8'h22 || overrun !== 1'b1 || q.size() != 0) begin
            n_fail++; $display("FAIL overrun_set: got data=%h ov=%b pending=%0d, expected 22 1 0", data, overrun, q.size());
        end
    endtask

    task automatic test_back_to_back_rd;
        logic ok;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        q.push_back(8'h11);
        q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                wait_valid(ok);
                n_chk++;
                if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got no Rx_valid, expected one"); end
                pulse_rd();
            end
        join
        repeat (4) @(negedge clk);
        n_chk++;
        if (data !== 8'h22 || overrun !== 1'b0 || Rx_full !== 1'b1) begin
            n_fail++; $display("FAIL b2b_rd: got data=%h ov=%b full=%b, expected 22 0 1", data, overrun, Rx_full);
        end
    endtask

    task automatic test_loopback;
        logic       ok;
        logic [7:0] lb [4] = '{8'h00, 8'hFF, 8'h55, 8'hAA};
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        fork
            for (int i = 0; i < 4; i++) begin
                q.push_back(lb[i]);
                send_frame(lb[i], 1'b1);
            end
            repeat (4) begin
                wait_valid(ok);
                n_chk++;
                if (!ok) begin n_fail++; $display("FAIL loop_timeout: got no Rx_valid, expected one"); end
                pulse_rd();
            end
        join
        repeat (4) @(negedge clk);
        n_chk++;
        if (q.size() != 0 || frame_err !== 1'b0 || overrun !== 1'b0 || data !== 8'hAA) begin
            n_fail++; $display("FAIL loop_status: got pending=%0d fe=%b ov=%b data=%h, expected 0 0 0 aa",
                               q.size(), frame_err, overrun, data);
        end
    endtask

    task automatic test_reset_mid;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (BIT * 4 + 4) @(negedge clk);
                n_chk++;
                if (Rx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b, expected 1", Rx_busy); end
                rst = 1'b0;
                #1;
                n_chk++;
                if ({data, Rx_valid, Rx_full, Rx_busy, frame_err, overrun} !== 13'h0) begin
                    n_fail++;
                    $display("FAIL mid_reset_outputs: got data=%h v=%b f=%b b=%b fe=%b ov=%b, expected all 0",
                             data, Rx_valid, Rx_full, Rx_busy, frame_err, overrun);
                end
            end
        join
        rst = 1'b1;
        repeat (4) @(negedge clk);
        q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++;
        if (data !== 8'h5A || q.size() != 0) begin
            n_fail++; $display("FAIL mid_recover: got data=%h pending=%0d, expected 5a 0", data, q.size());
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (Rx_valid) begin
                    n_valid++;
                    n_chk++;
                    if (q.size() == 0) begin
                        n_fail++; $display("FAIL sb_unexpected: got byte %h, expected none", data);
                    end else begin
                        exp_b = q.pop_front();
                        if (data !== exp_b) begin n_fail++; $display("FAIL sb_data: got %h, expected %h", data, exp_b); end
                    end
                    n_chk++;
                    if (prev_v) begin n_fail++; $display("FAIL sb_pulse_width: got 2+ cycles, expected 1"); end
                end
                prev_v = Rx_valid;
            end
        join_none
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back_rd();
        test_loopback();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
